// File: rtl/seq_div_pkg.sv
// Shared types and constants for the seq_div restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient reported for a zero divisor: all ones at the given width.
  function automatic logic [31:0] dbz_quotient(input int width);
    if (width >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference or restore.
module seq_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  // A set top bit of the shifted remainder means it already exceeds any
  // divisor, and the low bits of the wrapped subtraction are then exact.
  always_comb begin
    shifted        = {rem_in, dividend_bit};
    {borrow, diff} = {1'b0, shifted[WIDTH-1:0]} - {1'b0, divisor};
    q_bit          = shifted[WIDTH] | ~borrow;
    rem_out        = q_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional abort input is enabled by defining SEQ_DIV_ABORT_EN.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic             load, step, finish;
  logic             last_step;

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_r),
    .dividend_bit (quo_r[WIDTH-1]),
    .divisor      (div_r),
    .rem_out      (rem_next),
    .q_bit        (q_bit)
  );

  assign last_step = (count == CNT_W'(WIDTH - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
`ifdef SEQ_DIV_ABORT_EN
        if (abort) begin
          state_next = IDLE;
        end else
`endif
        begin
          step = 1'b1;
          if (last_step) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // quo_r starts as the dividend and shifts quotient bits in from the right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      div_r       <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        count <= '0;
        rem_r <= '0;
        quo_r <= dividend;
        div_r <= divisor;
      end else if (step) begin
        count <= count + CNT_W'(1);
        rem_r <= rem_next;
        quo_r <= {quo_r[WIDTH-2:0], q_bit};
      end
      if (finish) begin
        quotient    <= (div_r == '0) ? WIDTH'(dbz_quotient(WIDTH)) : quo_r;
        remainder   <= rem_r;
        div_by_zero <= (div_r == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard testbench for seq_div (WIDTH=8); abort test under SEQ_DIV_ABORT_EN.
module tb_seq_div;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    int               acc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
`ifdef SEQ_DIV_ABORT_EN
  logic             abort = 1'b0;
`endif
  logic             busy, done, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;

  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  exp_t sb[$];

  seq_div #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SEQ_DIV_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input int acc);
    exp_t e;
    e.acc = acc;
    if (b == 0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic waitIdle();
    bit idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    checkOutput("idle_timeout", {31'd0, idle}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int acc;
    waitIdle();
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1 acc = cycle;
    sb.push_back(model(a, b, acc));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("quotient", {24'd0, quotient}, {24'd0, e.q});
        checkOutput("remainder", {24'd0, remainder}, {24'd0, e.r});
        checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        checkOutput("latency", cycle - e.acc, WIDTH + 1);
      end
    end
  end

  initial begin
    int acc;
    logic [WIDTH-1:0] edge_a [8] = '{8'd0, 8'd1, 8'd6, 8'd7, 8'd255, 8'd255, 8'd128, 8'd0};
    logic [WIDTH-1:0] edge_b [8] = '{8'd5, 8'd1, 8'd7, 8'd7, 8'd255, 8'd254, 8'd3, 8'd0};

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_quotient", {24'd0, quotient}, 32'd0);
    checkOutput("reset_remainder", {24'd0, remainder}, 32'd0);
    checkOutput("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(8'd100, 8'd7);
    applyStimulus(8'd5, 8'd0);

    // Reset in the middle of 200/9 wipes outputs at once and drops the result.
    waitIdle();
    waitIdle();
    applyStimulus(8'd200, 8'd9);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_done", {31'd0, done}, 32'd0);
    checkOutput("midreset_quotient", {24'd0, quotient}, 32'd0);
    checkOutput("midreset_remainder", {24'd0, remainder}, 32'd0);
    checkOutput("midreset_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'd200, 8'd9);

    // Start held high through RUN/DONE: second request accepted only in IDLE.
    waitIdle();
    start    = 1'b1;
    dividend = 8'd255;
    divisor  = 8'd1;
    @(posedge clk);
    #1 acc = cycle;
    sb.push_back(model(8'd255, 8'd1, acc));
    @(negedge clk);
    dividend = 8'd3;
    divisor  = 8'd200;
    sb.push_back(model(8'd3, 8'd200, acc + WIDTH + 2));
    repeat (WIDTH + 2) @(posedge clk);
    @(negedge clk);
    start = 1'b0;

`ifdef SEQ_DIV_ABORT_EN
    applyStimulus(8'd100, 8'd7);
    applyStimulus(8'd77, 8'd5);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    sb.delete();
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    repeat (15) @(negedge clk);
    checkOutput("abort_quotient", {24'd0, quotient}, 32'd14);
    checkOutput("abort_remainder", {24'd0, remainder}, 32'd2);
    checkOutput("abort_dbz", {31'd0, div_by_zero}, 32'd0);
`endif

    for (int i = 0; i < 8; i++) begin
      applyStimulus(edge_a[i], edge_b[i]);
    end

    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] a, b;
      a = WIDTH'($urandom_range(0, 255));
      b = (i % 16 == 0) ? '0 : WIDTH'($urandom_range(0, 255));
      applyStimulus(a, b);
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(negedge clk);
    end
    checkOutput("drain", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
